dmem_responder: RTL and testbench

- Data-memory responder for the single-cycle MIPS datapath: the memory end of the CPU load/store interface (addr, wrdata, MemRead, MemWrite -> rddata).
- Word-addressed storage with a programmable access latency and a ready/busy handshake, so the datapath can later be stalled on slow memory.
- Sits between ALU result / rd2 and the MemtoReg write-back mux.

---
 rtl/dmem_if.sv | 21 ++
 rtl/dmem_responder.sv | 129 ++++++++++++
 tb/tb_dmem_responder.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/dmem_if.sv
// CPU load/store bus between the MIPS datapath (master) and the data-memory responder (slave).
interface dmem_if;
    logic [31:0] addr;
    logic [31:0] wrdata;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] rddata;
    logic        ready;
    logic        busy;
    logic        err;

    modport master (
        output addr, wrdata, MemRead, MemWrite,
        input  rddata, ready, busy, err
    );

    modport slave (
        input  addr, wrdata, MemRead, MemWrite,
        output rddata, ready, busy, err
    );
endinterface

// File: rtl/dmem_responder.sv
// Word-addressed data memory with programmable latency and a ready/busy handshake.
// Optional sticky misalignment detection is enabled by defining DMEM_ALIGN_CHECK_EN.
module dmem_responder #(
    parameter int DEPTH = 64,
    parameter int AW    = 6,
    parameter int LAT   = 2
) (
    input logic   clock,
    input logic   reset,
    dmem_if.slave bus
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;
    localparam logic [3:0] LAT_M1  = 4'(LAT - 1);
    localparam logic [31:0] BAD_WORD = 32'hDEAD_BEEF;

    logic [1:0]    state_r;
    logic [3:0]    cnt_r;
    logic [AW-1:0] idx_r;
    logic [31:0]   data_r;
    logic          store_r;
    logic          mis_r;
    logic [31:0]   rddata_r;
    logic          ready_r;
    logic          busy_r;
    logic [31:0]   mem_r [DEPTH];

    logic          req_s;
    logic [AW-1:0] idx_s;
    logic          mis_s;

    assign req_s = bus.MemRead | bus.MemWrite;
    assign idx_s = bus.addr[AW+1:2];

`ifdef DMEM_ALIGN_CHECK_EN
    logic err_r;
    logic unused_addr_s;

    assign mis_s         = (bus.addr[1:0] != 2'b00);
    assign unused_addr_s = ^bus.addr[31:AW+2];
    assign bus.err       = err_r;

    // Sticky misalignment flag, raised at the accept edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            err_r <= 1'b0;
        end else if ((state_r == ST_IDLE) && req_s && mis_s) begin
            err_r <= 1'b1;
        end else begin
            err_r <= err_r;
        end
    end
`else
    logic unused_addr_s;

    assign mis_s         = 1'b0;
    assign unused_addr_s = ^{bus.addr[31:AW+2], bus.addr[1:0]};
    assign bus.err       = 1'b0;
`endif

    assign bus.rddata = rddata_r;
    assign bus.ready  = ready_r;
    assign bus.busy   = busy_r;

    // Access sequencer: capture at accept, count down the latency, commit on entry to DONE.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r  <= ST_IDLE;
            cnt_r    <= 4'd0;
            idx_r    <= '0;
            data_r   <= 32'h0;
            store_r  <= 1'b0;
            mis_r    <= 1'b0;
            rddata_r <= 32'h0;
            ready_r  <= 1'b0;
            busy_r   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= 32'h0;
            end
        end else begin
            ready_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (req_s) begin
                        state_r <= ST_WAIT;
                        busy_r  <= 1'b1;
                        cnt_r   <= LAT_M1;
                        idx_r   <= idx_s;
                        data_r  <= bus.wrdata;
                        // a simultaneous read and write is treated as a store
                        store_r <= bus.MemWrite;
                        mis_r   <= mis_s;
                    end else begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    if (cnt_r != 4'd0) begin
                        cnt_r <= cnt_r - 4'd1;
                    end else begin
                        state_r <= ST_DONE;
                        ready_r <= 1'b1;
                        if (store_r) begin
                            if (!mis_r) begin
                                mem_r[idx_r] <= data_r;
                            end else begin
                                mem_r[idx_r] <= mem_r[idx_r];
                            end
                        end else begin
                            rddata_r <= mis_r ? BAD_WORD : mem_r[idx_r];
                        end
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed and random accesses against a word-array reference model.
module tb_dmem_responder;

    localparam int DEPTH = 64;
    localparam int LAT   = 2;
`ifdef DMEM_ALIGN_CHECK_EN
    localparam bit ALIGN_EN = 1'b1;
`else
    localparam bit ALIGN_EN = 1'b0;
`endif

    logic clock;
    logic reset;
    int   checks;
    int   failures;

    logic [31:0] model_mem [DEPTH];
    logic [31:0] model_rd;
    logic        model_err;

    dmem_if bus0 ();
    dmem_if bus1 ();

    dmem_responder #(.DEPTH(DEPTH), .AW(6), .LAT(LAT)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus0)
    );

    dmem_responder #(.DEPTH(DEPTH), .AW(6), .LAT(1)) dut1 (
        .clock (clock),
        .reset (reset),
        .bus   (bus1)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) model_mem[i] = 32'h0;
        model_rd  = 32'h0;
        model_err = 1'b0;
    endtask

    task automatic model_access(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] d);
        int unsigned idx;
        bit mis;
        idx = (a / 4) % DEPTH;
        mis = ALIGN_EN && ((a % 4) != 0);
        if (mis) model_err = 1'b1;
        if (wr) begin
            if (!mis) model_mem[idx] = d;
        end else if (rd) begin
            model_rd = mis ? 32'hDEAD_BEEF : model_mem[idx];
        end
    endtask

    // Called at a negedge with the LAT=2 instance idle; returns at a negedge with it idle again.
    task automatic access(input string tag, input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] d);
        logic [31:0] old_rd;
        old_rd = model_rd;
        bus0.addr     = a;
        bus0.wrdata   = d;
        bus0.MemRead  = rd;
        bus0.MemWrite = wr;
        model_access(rd, wr, a, d);
        for (int n = 0; n <= LAT + 1; n++) begin
            @(negedge clock);
            if (n == 0) begin
                bus0.MemRead  = 1'b0;
                bus0.MemWrite = 1'b0;
                bus0.addr     = $urandom;
                bus0.wrdata   = $urandom;
            end
            check({tag, "_ready"}, {31'd0, bus0.ready}, {31'd0, n == LAT});
            check({tag, "_busy"},  {31'd0, bus0.busy},  {31'd0, n <= LAT});
            check({tag, "_rddata"}, bus0.rddata, (n < LAT) ? old_rd : model_rd);
            if (n == LAT) check({tag, "_err"}, {31'd0, bus0.err}, {31'd0, model_err});
        end
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] held_val;
        int op;
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        bus0.addr = 32'h0; bus0.wrdata = 32'h0; bus0.MemRead = 1'b0; bus0.MemWrite = 1'b0;
        bus1.addr = 32'h0; bus1.wrdata = 32'h0; bus1.MemRead = 1'b0; bus1.MemWrite = 1'b0;
        model_reset();
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        check("rst_rddata", bus0.rddata, 32'h0);
        check("rst_ready", {31'd0, bus0.ready}, 32'd0);
        check("rst_busy",  {31'd0, bus0.busy},  32'd0);
        check("rst_err",   {31'd0, bus0.err},   32'd0);

        // Basic store then load
        access("st10", 1'b0, 1'b1, 32'h10, 32'h1234_5678);
        access("ld10", 1'b1, 1'b0, 32'h10, 32'h0);
        check("ld10_value", bus0.rddata, 32'h1234_5678);

        // Address wrap modulo DEPTH*4
        access("st04", 1'b0, 1'b1, 32'h04, 32'hCAFE_F00D);
        access("ld104", 1'b1, 1'b0, 32'h104, 32'h0);
        check("ld104_value", bus0.rddata, 32'hCAFE_F00D);

        // Read and write together act as a store
        access("rw20", 1'b1, 1'b1, 32'h20, 32'hA5A5_A5A5);
        check("rw20_rd_kept", bus0.rddata, 32'hCAFE_F00D);
        access("ld20", 1'b1, 1'b0, 32'h20, 32'h0);
        check("ld20_value", bus0.rddata, 32'hA5A5_A5A5);

        // Random traffic over a handful of words with random upper address bits
        for (int k = 0; k < 24; k++) begin
            a  = ($urandom & 32'hFFFF_FF00) | ($urandom_range(0, 7) << 2);
            d  = $urandom;
            op = $urandom_range(0, 2);
            access("rand", (op != 1), (op != 0), a, d);
        end

        // Misaligned accesses
        access("st10b", 1'b0, 1'b1, 32'h10, 32'h0BAD_CAFE);
        access("ld13", 1'b1, 1'b0, 32'h13, 32'h0);
        access("st11", 1'b0, 1'b1, 32'h11, 32'h5555_AAAA);
        access("ld10b", 1'b1, 1'b0, 32'h10, 32'h0);
        check("err_sticky", {31'd0, bus0.err}, {31'd0, model_err});

        // Reset during WAIT of a store aborts it
        bus0.addr = 32'h30; bus0.wrdata = 32'h7777_7777; bus0.MemWrite = 1'b1;
        @(negedge clock);
        bus0.MemWrite = 1'b0;
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        model_reset();
        check("abort_rddata", bus0.rddata, 32'h0);
        check("abort_ready", {31'd0, bus0.ready}, 32'd0);
        check("abort_busy",  {31'd0, bus0.busy},  32'd0);
        check("abort_err",   {31'd0, bus0.err},   32'd0);
        for (int n = 0; n < LAT + 2; n++) begin
            @(negedge clock);
            check("abort_no_ready", {31'd0, bus0.ready}, 32'd0);
        end
        access("ld30", 1'b1, 1'b0, 32'h30, 32'h0);
        check("ld30_value", bus0.rddata, 32'h0);
        access("ld20r", 1'b1, 1'b0, 32'h20, 32'h0);

        // Held store on the LAT=1 instance: accepts every third cycle, data sampled only at accept
        bus1.addr = 32'h40; bus1.wrdata = 32'h1111_1111; bus1.MemWrite = 1'b1;
        held_val = 32'h0;
        for (int n = 0; n < 8; n++) begin
            @(negedge clock);
            check("held_ready", {31'd0, bus1.ready}, {31'd0, (n % 3) == 1});
            check("held_busy",  {31'd0, bus1.busy},  {31'd0, (n % 3) != 2});
            if ((n % 3) == 2) begin
                held_val    = $urandom;
                bus1.wrdata = held_val;
            end else begin
                bus1.wrdata = $urandom;
            end
            if (n == 7) bus1.MemWrite = 1'b0;
        end
        @(negedge clock);
        bus1.MemRead = 1'b1;
        @(negedge clock);
        bus1.MemRead = 1'b0;
        check("held_ld_wait", {31'd0, bus1.ready}, 32'd0);
        @(negedge clock);
        check("held_ld_ready", {31'd0, bus1.ready}, 32'd1);
        check("held_ld_value", bus1.rddata, held_val);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
